pc_gen: RTL and testbench
=========================

# pc_gen

Parametrised program-counter generator for the fetch stage, successor to the combinational next-PC logic. It owns the PC register and selects the next PC from four redirect sources by fixed priority: exception, eret, jump, branch. A one-entry pending-redirect buffer keeps a redirect raised during a stall so it is not lost. Sits between the hazard unit and instruction memory.

## Interface
- `WIDTH`, 32: address width in bits; must be ≥ 3.
- `RESET_PC`, 32'h0000_3000: PC value loaded by reset.
- `EXC_PC`, 32'h0000_4180: exception handler entry address.
- `clk`  in  1  single clock; all state updates on rising edge.
- `reset`  in  1  synchronous, active-low reset.
- `stall`  in  1  hold PC (hazard unit).
- `branch`  in  1  branch taken; target `branch_addr`.
- `branch_addr`  in  WIDTH  branch target.
- `jump`  in  1  jump; target `jump_addr`.
- `jump_addr`  in  WIDTH  jump target.
- `eret`  in  1  return from exception; target `epc`.
- `epc`  in  WIDTH  exception return address.
- `exc`  in  1  exception taken; target `EXC_PC`.
- `pc`  out  WIDTH  current fetch address (registered).
- `pc_plus4`  out  WIDTH  `pc + 4`, modulo 2^WIDTH.
- `pc_plus8`  out  WIDTH  `pc + 8`, modulo 2^WIDTH (link address).
- `pend_valid`  out  1  pending redirect held (registered).
- `pend_src`  out  2  source code of the pending redirect (registered).
- `pc_misaligned`  out  1  `pc[1:0] != 0`. Combinational from `pc`.

## Operation
- Source codes and priority: EXC=3 > ERET=2 > JUMP=1 > BR=0. The live request is the highest-priority asserted input.
- Candidate redirect each cycle:
  - live request, if its code ≥ `pend_src` or `pend_valid`=0;
  - otherwise the pending entry.
- PC update on each edge:
  - `exc`=1: `pc`←`EXC_PC` regardless of `stall`; pending cleared.
  - else `stall`=0 and a candidate exists: `pc`←candidate target; pending cleared.
  - else `stall`=0: `pc`←`pc_plus4`.
  - else (stalled): `pc` holds.
- Pending buffer while `stall`=1, `exc`=0, and a live request exists:
  - empty: capture source code and target;
  - occupied: overwrite only if the live code ≥ `pend_src`. A lower-priority live request is dropped.
- No live request while stalled: pending holds.
- Arithmetic: all adds unsigned, WIDTH bits, wrap silently (all-ones minus 3, plus 4 → 0). Targets are taken verbatim; a misaligned target is loaded and flagged via `pc_misaligned`. The block never traps itself.

## Timing
- Reset (`reset`=0 at edge), with priority over everything: `pc`=`RESET_PC`, `pend_valid`=0, `pend_src`=0. Therefore `pc_plus4`=`RESET_PC`+4, `pc_plus8`=`RESET_PC`+8, `pc_misaligned`=`RESET_PC[1:0]!=0`.
- Reset asserted mid-stall with a pending entry discards the entry.
- Redirect latency: a request in cycle n appears on `pc` in cycle n+1 if unstalled. If stalled, it appears in the cycle after the first unstalled edge.
- `exc` latency is always 1 cycle.
- `pend_valid` rises the cycle after the stalled request. It falls the cycle after the pending target is applied or an exception hits.
- Simultaneous events:
  - same-edge `branch`+`jump`: jump wins.
  - release cycle with a live jump and a pending branch: jump wins; the branch is discarded.
  - live branch with a pending eret: eret applied.

## Structure
- Shared package `cpu_pkg`: source code constants `SRC_BR`, `SRC_J`, `SRC_ERET`, `SRC_EXC` (2-bit) and the default `RESET_PC`/`EXC_PC` values.
- One combinational sub-module, `redirect_arb`: takes the four requests and targets; outputs `live_valid`, `live_src`, `live_addr`.
- PC register, pending register, and candidate select live in `pc_gen`.

## Test plan
- Reset low for 2 cycles, then release with no stimulus → `pc` = 0x3000, 0x3004, 0x3008 on successive cycles; `pend_valid`=0.
- `branch`=1, `branch_addr`=0x3100, unstalled at `pc`=0x3008 → next `pc`=0x3100; pending never set.
- `stall`=1 for 3 cycles; `jump` pulse to 0x3400 in stall cycle 1, `branch` pulse to 0x3200 in cycle 2 → `pend_src`=1 holding 0x3400 (branch dropped); after release `pc`=0x3400, `pend_valid`=0.
- Stalled with pending branch 0x3200; `exc` pulse → next `pc`=0x4180 despite stall; `pend_valid`=0.
- `jump_addr`=0x3002 → `pc`=0x3002, `pc_misaligned`=1; `pc`=0xFFFF_FFFC unstalled → next `pc`=0x0000_0000, `pc_plus8`=0x0000_0004 at 0xFFFF_FFFC.
- Pending eret to 0x3050; `reset`=0 during stall → `pc`=0x3000, `pend_valid`=0; after release, no redirect to 0x3050 occurs.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared fetch-stage constants: redirect source codes (higher code wins)
// and the default reset / exception-entry addresses.
package cpu_pkg;

  localparam logic [1:0] SRC_BR   = 2'd0;
  localparam logic [1:0] SRC_J    = 2'd1;
  localparam logic [1:0] SRC_ERET = 2'd2;
  localparam logic [1:0] SRC_EXC  = 2'd3;

  localparam logic [31:0] DEF_RESET_PC = 32'h0000_3000;
  localparam logic [31:0] DEF_EXC_PC   = 32'h0000_4180;

endpackage

// File: rtl/redirect_arb.sv
// Fixed-priority pick of the live redirect (exc > eret > jump > branch).
// Purely combinational, zero latency, no backpressure.
module redirect_arb
  import cpu_pkg::*;
#(
  parameter int               WIDTH  = 32,
  parameter logic [WIDTH-1:0] EXC_PC = WIDTH'(DEF_EXC_PC)
) (
  input  logic             branch,
  input  logic [WIDTH-1:0] branch_addr,
  input  logic             jump,
  input  logic [WIDTH-1:0] jump_addr,
  input  logic             eret,
  input  logic [WIDTH-1:0] epc,
  input  logic             exc,
  output logic             live_valid,
  output logic [1:0]       live_src,
  output logic [WIDTH-1:0] live_addr
);

  always_comb begin
    live_valid = exc | eret | jump | branch;
    live_src   = SRC_BR;
    live_addr  = branch_addr;
    if (exc) begin
      live_src  = SRC_EXC;
      live_addr = EXC_PC;
    end else if (eret) begin
      live_src  = SRC_ERET;
      live_addr = epc;
    end else if (jump) begin
      live_src  = SRC_J;
      live_addr = jump_addr;
    end
  end

endmodule

// File: rtl/pc_gen.sv
// PC register with prioritised redirects; redirect visible one cycle after the request.
// Stall holds pc; a redirect seen while stalled is parked in a one-entry buffer.
module pc_gen
  import cpu_pkg::*;
#(
  parameter int               WIDTH    = 32,
  parameter logic [WIDTH-1:0] RESET_PC = WIDTH'(DEF_RESET_PC),
  parameter logic [WIDTH-1:0] EXC_PC   = WIDTH'(DEF_EXC_PC)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             stall,
  input  logic             branch,
  input  logic [WIDTH-1:0] branch_addr,
  input  logic             jump,
  input  logic [WIDTH-1:0] jump_addr,
  input  logic             eret,
  input  logic [WIDTH-1:0] epc,
  input  logic             exc,
  output logic [WIDTH-1:0] pc,
  output logic [WIDTH-1:0] pc_plus4,
  output logic [WIDTH-1:0] pc_plus8,
  output logic             pend_valid,
  output logic [1:0]       pend_src,
  output logic             pc_misaligned
);

  logic             live_valid;
  logic [1:0]       live_src;
  logic [WIDTH-1:0] live_addr;
  logic [WIDTH-1:0] pend_addr;
  logic             take_live;
  logic             cand_valid;
  logic [WIDTH-1:0] cand_addr;

  redirect_arb #(
    .WIDTH  (WIDTH),
    .EXC_PC (EXC_PC)
  ) u_arb (
    .branch      (branch),
    .branch_addr (branch_addr),
    .jump        (jump),
    .jump_addr   (jump_addr),
    .eret        (eret),
    .epc         (epc),
    .exc         (exc),
    .live_valid  (live_valid),
    .live_src    (live_src),
    .live_addr   (live_addr)
  );

  assign pc_plus4      = pc + WIDTH'(4);
  assign pc_plus8      = pc + WIDTH'(8);
  assign pc_misaligned = (pc[1:0] != 2'b00);

  // An equal-or-higher priority live request supersedes the parked one.
  assign take_live  = live_valid && (!pend_valid || (live_src >= pend_src));
  assign cand_valid = take_live || pend_valid;
  assign cand_addr  = take_live ? live_addr : pend_addr;

  always_ff @(posedge clk) begin
    if (!reset) begin
      pc         <= RESET_PC;
      pend_valid <= 1'b0;
      pend_src   <= SRC_BR;
      pend_addr  <= '0;
    end else if (exc) begin
      pc         <= EXC_PC;
      pend_valid <= 1'b0;
      pend_src   <= SRC_BR;
    end else if (!stall) begin
      pc         <= cand_valid ? cand_addr : pc_plus4;
      pend_valid <= 1'b0;
      pend_src   <= SRC_BR;
    end else if (take_live) begin
      pend_valid <= 1'b1;
      pend_src   <= live_src;
      pend_addr  <= live_addr;
    end
  end

endmodule

// File: tb/tb_pc_gen.sv
// Directed vector table plus randomized run against a spec-level reference model.
module tb_pc_gen;

  localparam logic [31:0] RST_PC = 32'h0000_3000;
  localparam logic [31:0] EXC_A  = 32'h0000_4180;

  logic        clk = 1'b0;
  logic        reset, stall, branch, jump, eret, exc;
  logic [31:0] branch_addr, jump_addr, epc;
  logic [31:0] pc, pc_plus4, pc_plus8;
  logic        pend_valid, pc_misaligned;
  logic [1:0]  pend_src;

  always #5 clk = ~clk;

  pc_gen dut (
    .clk           (clk),
    .reset         (reset),
    .stall         (stall),
    .branch        (branch),
    .branch_addr   (branch_addr),
    .jump          (jump),
    .jump_addr     (jump_addr),
    .eret          (eret),
    .epc           (epc),
    .exc           (exc),
    .pc            (pc),
    .pc_plus4      (pc_plus4),
    .pc_plus8      (pc_plus8),
    .pend_valid    (pend_valid),
    .pend_src      (pend_src),
    .pc_misaligned (pc_misaligned)
  );

  typedef struct {
    logic        rst_n;
    logic        stl;
    logic        br;
    logic [31:0] ba;
    logic        jp;
    logic [31:0] ja;
    logic        er;
    logic [31:0] ep;
    logic        ex;
    logic [31:0] exp_pc;
    logic        exp_pv;
    logic [1:0]  exp_ps;
  } vec_t;

  vec_t tbl[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  // reference model state: pc plus an optional parked redirect
  logic [31:0] m_pc;
  logic        m_pv;
  int          m_ps;
  logic [31:0] m_pa;

  function automatic vec_t mk(logic rst_n, logic stl, logic br, logic [31:0] ba,
                              logic jp, logic [31:0] ja, logic er, logic [31:0] ep,
                              logic ex, logic [31:0] epc_v, logic pv, logic [1:0] ps);
    vec_t v;
    v.rst_n = rst_n; v.stl = stl; v.br = br; v.ba = ba; v.jp = jp; v.ja = ja;
    v.er = er; v.ep = ep; v.ex = ex; v.exp_pc = epc_v; v.exp_pv = pv; v.exp_ps = ps;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_step(input vec_t v);
    logic [31:0] tgt [4];
    int          live;
    logic        use_live;
    tgt[0] = v.ba; tgt[1] = v.ja; tgt[2] = v.ep; tgt[3] = EXC_A;
    live = -1;
    if (v.br) live = 0;
    if (v.jp) live = 1;
    if (v.er) live = 2;
    if (v.ex) live = 3;
    use_live = (live >= 0) && (!m_pv || live >= m_ps);
    if (!v.rst_n) begin
      m_pc = RST_PC; m_pv = 1'b0; m_ps = 0;
    end else if (v.ex) begin
      m_pc = EXC_A; m_pv = 1'b0; m_ps = 0;
    end else if (!v.stl) begin
      if (use_live)  m_pc = tgt[live];
      else if (m_pv) m_pc = m_pa;
      else           m_pc = m_pc + 32'd4;
      m_pv = 1'b0; m_ps = 0;
    end else if (use_live) begin
      m_pv = 1'b1; m_ps = live; m_pa = tgt[live];
    end
  endtask

  task automatic check_outs(input string tag, input logic [31:0] epcv, input logic epv,
                            input logic [1:0] eps);
    chk({tag, ".pc"}, pc, epcv);
    chk({tag, ".pc_plus4"}, pc_plus4, epcv + 32'd4);
    chk({tag, ".pc_plus8"}, pc_plus8, epcv + 32'd8);
    chk({tag, ".misaligned"}, {31'd0, pc_misaligned}, {31'd0, epcv[1:0] != 2'b00});
    chk({tag, ".pend_valid"}, {31'd0, pend_valid}, {31'd0, epv});
    if (epv) chk({tag, ".pend_src"}, {30'd0, pend_src}, {30'd0, eps});
  endtask

  task automatic apply(input vec_t v);
    reset = v.rst_n; stall = v.stl; branch = v.br; branch_addr = v.ba;
    jump = v.jp; jump_addr = v.ja; eret = v.er; epc = v.ep; exc = v.ex;
    @(posedge clk);
    model_step(v);
    #1;
  endtask

  initial begin
    vec_t v;
    m_pc = RST_PC; m_pv = 1'b0; m_ps = 0; m_pa = '0;
    reset = 1'b0; stall = 1'b0; branch = 1'b0; jump = 1'b0; eret = 1'b0; exc = 1'b0;
    branch_addr = '0; jump_addr = '0; epc = '0;

    //          rst st br ba            jp ja            er ep            ex exp_pc        pv ps
    tbl.push_back(mk(0, 0, 0, 0,            0, 0,            0, 0,            0, 32'h3000,     0, 0));
    tbl.push_back(mk(0, 0, 0, 0,            0, 0,            0, 0,            0, 32'h3000,     0, 0));
    tbl.push_back(mk(1, 0, 0, 0,            0, 0,            0, 0,            0, 32'h3004,     0, 0));
    tbl.push_back(mk(1, 0, 0, 0,            0, 0,            0, 0,            0, 32'h3008,     0, 0));
    tbl.push_back(mk(1, 0, 1, 32'h3100,     0, 0,            0, 0,            0, 32'h3100,     0, 0));
    tbl.push_back(mk(1, 1, 0, 0,            1, 32'h3400,     0, 0,            0, 32'h3100,     1, 1));
    tbl.push_back(mk(1, 1, 1, 32'h3200,     0, 0,            0, 0,            0, 32'h3100,     1, 1));
    tbl.push_back(mk(1, 1, 0, 0,            0, 0,            0, 0,            0, 32'h3100,     1, 1));
    tbl.push_back(mk(1, 0, 0, 0,            0, 0,            0, 0,            0, 32'h3400,     0, 0));
    tbl.push_back(mk(1, 1, 1, 32'h3200,     0, 0,            0, 0,            0, 32'h3400,     1, 0));
    tbl.push_back(mk(1, 1, 0, 0,            0, 0,            0, 0,            1, 32'h4180,     0, 0));
    tbl.push_back(mk(1, 0, 0, 0,            1, 32'h3002,     0, 0,            0, 32'h3002,     0, 0));
    tbl.push_back(mk(1, 0, 0, 0,            0, 0,            0, 0,            0, 32'h3006,     0, 0));
    tbl.push_back(mk(1, 0, 0, 0,            1, 32'hFFFF_FFFC, 0, 0,           0, 32'hFFFF_FFFC, 0, 0));
    tbl.push_back(mk(1, 0, 0, 0,            0, 0,            0, 0,            0, 32'h0000_0000, 0, 0));
    tbl.push_back(mk(1, 1, 0, 0,            0, 0,            1, 32'h3050,     0, 32'h0,        1, 2));
    tbl.push_back(mk(1, 1, 1, 32'h3200,     0, 0,            0, 0,            0, 32'h0,        1, 2));
    tbl.push_back(mk(0, 1, 0, 0,            0, 0,            0, 0,            0, 32'h3000,     0, 0));
    tbl.push_back(mk(1, 0, 0, 0,            0, 0,            0, 0,            0, 32'h3004,     0, 0));
    tbl.push_back(mk(1, 1, 0, 0,            0, 0,            1, 32'h3050,     0, 32'h3004,     1, 2));
    tbl.push_back(mk(1, 0, 1, 32'h3200,     0, 0,            0, 0,            0, 32'h3050,     0, 0));
    tbl.push_back(mk(1, 1, 1, 32'h3200,     0, 0,            0, 0,            0, 32'h3050,     1, 0));
    tbl.push_back(mk(1, 0, 0, 0,            1, 32'h3400,     0, 0,            0, 32'h3400,     0, 0));
    tbl.push_back(mk(1, 0, 1, 32'h3500,     1, 32'h3600,     0, 0,            0, 32'h3600,     0, 0));
    tbl.push_back(mk(1, 1, 0, 0,            1, 32'h3700,     0, 0,            0, 32'h3600,     1, 1));
    tbl.push_back(mk(1, 1, 0, 0,            1, 32'h3800,     0, 0,            0, 32'h3600,     1, 1));
    tbl.push_back(mk(1, 0, 0, 0,            0, 0,            0, 0,            0, 32'h3800,     0, 0));
    tbl.push_back(mk(1, 0, 0, 0,            1, 32'h3900,     0, 0,            1, 32'h4180,     0, 0));
    tbl.push_back(mk(1, 1, 0, 0,            1, 32'h3B00,     1, 32'h3A00,     0, 32'h4180,     1, 2));
    tbl.push_back(mk(1, 0, 0, 0,            0, 0,            0, 0,            0, 32'h3A00,     0, 0));

    for (int i = 0; i < tbl.size(); i++) begin
      apply(tbl[i]);
      check_outs($sformatf("vec%0d", i), tbl[i].exp_pc, tbl[i].exp_pv, tbl[i].exp_ps);
    end

    // randomized traffic, expected values from the reference model
    for (int i = 0; i < 3000; i++) begin
      v.rst_n = ($urandom_range(0, 99) >= 2);
      v.stl   = ($urandom_range(0, 99) < 45);
      v.br    = ($urandom_range(0, 99) < 25);
      v.jp    = ($urandom_range(0, 99) < 20);
      v.er    = ($urandom_range(0, 99) < 15);
      v.ex    = ($urandom_range(0, 99) < 4);
      v.ba    = $urandom & (($urandom_range(0, 9) == 0) ? 32'hFFFF_FFFF : 32'hFFFF_FFFC);
      v.ja    = $urandom & (($urandom_range(0, 9) == 0) ? 32'hFFFF_FFFF : 32'hFFFF_FFFC);
      v.ep    = $urandom & 32'hFFFF_FFFC;
      v.exp_pc = '0; v.exp_pv = 1'b0; v.exp_ps = '0;
      apply(v);
      check_outs($sformatf("rnd%0d", i), m_pc, m_pv, 2'(m_ps));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
